robo_ambiente: RTL
==================

Name: robo_ambiente

Overview:
- Grid-world model that closes the loop around the robot controller.
- Consumes the controller's command outputs (avancar, girar, recolher_entulho) and produces its sensor inputs (head, left, under, barrier) from an internal map, position and heading.
- Used as the plant in system-level benches and in FPGA demos.
- Map contents are loaded through a write port; robot pose is held in registers.

Parameters:
- COORD_W, 3, coordinate width; the grid is 2**COORD_W by 2**COORD_W cells.
- START_X, 0, x coordinate after reset.
- START_Y, 0, y coordinate after reset.
- START_DIR, 0, heading after reset (0=N, 1=E, 2=S, 3=W).
- EXIT_X, 7, x coordinate of the exit cell.
- EXIT_Y, 7, y coordinate of the exit cell.
- COLETA_CICLOS, 3, number of busy cycles for one debris collection (valid range 1..15).

Ports:
- clock  in  1  system clock; all registers update on posedge.
- reset  in  1  asynchronous, active-high.
- avancar  in  1  move-forward command.
- girar  in  1  rotate 90 degrees clockwise.
- recolher_entulho  in  1  collect debris in the front cell.
- map_we  in  1  map write strobe.
- map_addr  in  2*COORD_W  cell address = y*2**COORD_W + x.
- map_wall  in  1  wall bit to write.
- map_debris  in  1  debris bit to write.
- head  out  1  front cell is a wall or outside the grid.
- left  out  1  left cell is a wall or outside the grid.
- under  out  1  robot is standing on the exit cell.
- barrier  out  1  front cell holds debris and is not a wall.
- pos_x  out  COORD_W  current x.
- pos_y  out  COORD_W  current y.
- dir  out  2  current heading.
- busy  out  1  a collection is in progress.
- colisao  out  1  one-cycle pulse on a blocked avancar.
- cmd_erro  out  1  one-cycle pulse on an invalid command.
- entulho_cnt  out  8  debris cells removed; saturates at 255.

Behaviour:
- Reset values:
  - pos = START, dir = START_DIR.
  - Map all zero; every cell empty.
  - busy, colisao, cmd_erro, entulho_cnt = 0.
  - Sensors = 0.
- Direction vectors:
  - N is y+1, E is x+1, S is y-1, W is x-1.
  - Front cell = pos + vec(dir); left cell = pos + vec((dir-1) mod 4).
  - Any coordinate outside 0..2**COORD_W-1 counts as a wall. There is no wrap-around.
- States: LIVRE and COLETANDO.
- LIVRE: commands are sampled at posedge.
  - More than one command high: pulse cmd_erro, no action.
  - avancar:
    - If the front cell is a wall, out of bounds or holds debris, pulse colisao and keep the pose.
    - Otherwise update pos at this edge.
  - girar: dir <= (dir+1) mod 4.
  - recolher_entulho with barrier=1:
    - Go to COLETANDO, busy <= 1, load the counter with COLETA_CICLOS.
    - Latch the front cell address at this edge.
  - recolher_entulho with barrier=0: no action, no error.
- COLETANDO:
  - The counter decrements each cycle.
  - All commands are ignored; cmd_erro and colisao are not asserted.
  - When the counter reaches 0:
    - Clear the debris bit of the latched cell.
    - Increment entulho_cnt (saturating).
    - busy <= 0, return to LIVRE.
  - busy stays high for exactly COLETA_CICLOS cycles.
- Sensors:
  - Registered, computed from pose, map and exit at the previous edge.
  - Latency: a command accepted at edge N gives its pose change at edge N; the sensors reflect the new pose after edge N+1.
- Map writes:
  - Accepted in any state; take effect at the edge.
  - Sensors follow one edge later.
  - A write and a collection hitting the same cell on the same edge: the write wins.
  - A write to the robot's own cell is permitted and does not move the robot.
- under = (pos == EXIT).
- Reset asserted mid-collection aborts it: the map is cleared and entulho_cnt is not incremented.

Optional Feature:
- Macro: ROBO_AMBIENTE_VISITADOS_EN.
- When defined:
  - Add a visited bitmap of 2**(2*COORD_W) bits.
  - The start cell is marked at reset.
  - Each successful move marks the destination cell.
  - Add output visitados_cnt, width 2*COORD_W+1, counting distinct visited cells.
  - Reset value of visitados_cnt is 1.
- When undefined: no bitmap and no visitados_cnt port.

Test Plan:
- Reset with defaults, empty map -> pos (0,0), dir 0; after 1 edge head=0, left=1 (x=-1 out of bounds), under=0, barrier=0.
- From the default start, girar once -> dir=1. Then avancar twice -> pos (2,0), no colisao. Sensors then give head=0 and left=0 (front cell (3,0), left cell (2,1)).
- From the default start, write wall at (0,1), i.e. map_addr=8; then avancar -> colisao pulses 1 cycle, pos stays (0,0), head=1.
- From the default start, write debris at (0,1), then recolher_entulho:
  - barrier=1 beforehand.
  - busy high exactly 3 cycles; the avancar issued during busy is ignored.
  - Afterwards entulho_cnt=1 and barrier=0.
  - A following avancar moves to (0,1).
- avancar and girar high together -> cmd_erro pulses, pose unchanged. Reset during COLETANDO -> busy=0 and entulho_cnt=0 immediately.
- Drive the robot to (7,7) -> under=1 one edge after arrival. With ROBO_AMBIENTE_VISITADOS_EN defined, visitados_cnt equals the number of distinct cells on the path, start cell included.

Source files
------------

// File: rtl/robo_ambiente.sv
// robo_ambiente: grid-world plant closing the loop around the robot controller.
// Holds a wall/debris map, the robot pose and a debris-collection sequencer, and
// produces registered head/left/under/barrier sensor bits from them.
// Optional feature macro: ROBO_AMBIENTE_VISITADOS_EN adds a visited-cell bitmap
// and the visitados_cnt output (distinct cells visited, start cell included).
module robo_ambiente #(
    parameter int unsigned COORD_W       = 3,
    parameter int unsigned START_X       = 0,
    parameter int unsigned START_Y       = 0,
    parameter int unsigned START_DIR     = 0,
    parameter int unsigned EXIT_X        = 7,
    parameter int unsigned EXIT_Y        = 7,
    parameter int unsigned COLETA_CICLOS = 3
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 avancar,
    input  logic                 girar,
    input  logic                 recolher_entulho,
    input  logic                 map_we,
    input  logic [2*COORD_W-1:0] map_addr,
    input  logic                 map_wall,
    input  logic                 map_debris,
    output logic                 head,
    output logic                 left,
    output logic                 under,
    output logic                 barrier,
    output logic [COORD_W-1:0]   pos_x,
    output logic [COORD_W-1:0]   pos_y,
    output logic [1:0]           dir,
    output logic                 busy,
    output logic                 colisao,
    output logic                 cmd_erro,
`ifdef ROBO_AMBIENTE_VISITADOS_EN
    output logic [2*COORD_W:0]   visitados_cnt,
`endif
    output logic [7:0]           entulho_cnt
);

    localparam int unsigned AW    = 2 * COORD_W;
    localparam int unsigned CELLS = 1 << AW;
    localparam int unsigned CNT_W = 4;
    localparam logic [COORD_W-1:0] MAXC = '1;

    typedef enum logic {LIVRE, COLETANDO} state_t;

    state_t               r_state, w_state_nxt;
    logic [COORD_W-1:0]   r_pos_x, r_pos_y, w_pos_x_nxt, w_pos_y_nxt;
    logic [1:0]           r_dir, w_dir_nxt;
    logic [CNT_W-1:0]     r_cnt, w_cnt_nxt;
    logic                 r_busy, w_busy_nxt;
    logic                 r_colisao, w_colisao_nxt;
    logic                 r_cmd_erro, w_cmd_erro_nxt;
    logic [7:0]           r_entulho, w_entulho_nxt;
    logic [AW-1:0]        r_alvo, w_alvo_nxt;
    logic                 w_move_en;
    logic                 w_clear_en;

    logic [CELLS-1:0]     r_wall;
    logic [CELLS-1:0]     r_debris;

    logic                 r_head, r_left, r_under, r_barrier;

    // Neighbour of (x,y) in direction d: {out_of_grid, y, x}; no wrap-around.
    function automatic logic [AW:0] f_vizinho(input logic [COORD_W-1:0] x,
                                              input logic [COORD_W-1:0] y,
                                              input logic [1:0]         d);
        logic               oob;
        logic [COORD_W-1:0] nx;
        logic [COORD_W-1:0] ny;
        oob = 1'b0;
        nx  = x;
        ny  = y;
        case (d)
            2'd0: begin oob = (y == MAXC);  ny = y + COORD_W'(1); end
            2'd1: begin oob = (x == MAXC);  nx = x + COORD_W'(1); end
            2'd2: begin oob = (y == '0);    ny = y - COORD_W'(1); end
            default: begin oob = (x == '0); nx = x - COORD_W'(1); end
        endcase
        return {oob, ny, nx};
    endfunction

    logic [AW:0]   w_front;
    logic [AW:0]   w_leftc;
    logic          w_front_oob;
    logic [AW-1:0] w_front_addr;
    logic          w_left_oob;
    logic [AW-1:0] w_left_addr;
    logic          w_front_wall;
    logic          w_left_wall;
    logic          w_front_block;
    logic          w_barrier;
    logic          w_multi_cmd;

    assign w_front       = f_vizinho(r_pos_x, r_pos_y, r_dir);
    assign w_leftc       = f_vizinho(r_pos_x, r_pos_y, r_dir - 2'd1);
    assign w_front_oob   = w_front[AW];
    assign w_front_addr  = w_front[AW-1:0];
    assign w_left_oob    = w_leftc[AW];
    assign w_left_addr   = w_leftc[AW-1:0];
    assign w_front_wall  = w_front_oob | r_wall[w_front_addr];
    assign w_left_wall   = w_left_oob  | r_wall[w_left_addr];
    assign w_front_block = w_front_wall | r_debris[w_front_addr];
    assign w_barrier     = ~w_front_oob & r_debris[w_front_addr] & ~r_wall[w_front_addr];
    assign w_multi_cmd   = (avancar & girar) | (avancar & recolher_entulho) |
                           (girar & recolher_entulho);

    // State, pose and status registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= LIVRE;
            r_pos_x    <= COORD_W'(START_X);
            r_pos_y    <= COORD_W'(START_Y);
            r_dir      <= 2'(START_DIR);
            r_cnt      <= '0;
            r_busy     <= 1'b0;
            r_colisao  <= 1'b0;
            r_cmd_erro <= 1'b0;
            r_entulho  <= '0;
            r_alvo     <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_pos_x    <= w_pos_x_nxt;
            r_pos_y    <= w_pos_y_nxt;
            r_dir      <= w_dir_nxt;
            r_cnt      <= w_cnt_nxt;
            r_busy     <= w_busy_nxt;
            r_colisao  <= w_colisao_nxt;
            r_cmd_erro <= w_cmd_erro_nxt;
            r_entulho  <= w_entulho_nxt;
            r_alvo     <= w_alvo_nxt;
        end
    end

    // Command decode and collection sequencing.
    always_comb begin
        w_state_nxt    = r_state;
        w_pos_x_nxt    = r_pos_x;
        w_pos_y_nxt    = r_pos_y;
        w_dir_nxt      = r_dir;
        w_cnt_nxt      = r_cnt;
        w_busy_nxt     = r_busy;
        w_colisao_nxt  = 1'b0;
        w_cmd_erro_nxt = 1'b0;
        w_entulho_nxt  = r_entulho;
        w_alvo_nxt     = r_alvo;
        w_move_en      = 1'b0;
        w_clear_en     = 1'b0;
        case (r_state)
            LIVRE: begin
                if (w_multi_cmd) begin
                    w_cmd_erro_nxt = 1'b1;
                end else if (avancar) begin
                    if (w_front_block) begin
                        w_colisao_nxt = 1'b1;
                    end else begin
                        w_pos_x_nxt = w_front_addr[COORD_W-1:0];
                        w_pos_y_nxt = w_front_addr[AW-1:COORD_W];
                        w_move_en   = 1'b1;
                    end
                end else if (girar) begin
                    w_dir_nxt = r_dir + 2'd1;
                end else if (recolher_entulho && w_barrier) begin
                    w_state_nxt = COLETANDO;
                    w_busy_nxt  = 1'b1;
                    w_cnt_nxt   = CNT_W'(COLETA_CICLOS);
                    w_alvo_nxt  = w_front_addr;
                end
            end
            COLETANDO: begin
                if (r_cnt <= CNT_W'(1)) begin
                    w_cnt_nxt   = '0;
                    w_clear_en  = 1'b1;
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = LIVRE;
                    if (r_entulho != 8'hFF) begin
                        w_entulho_nxt = r_entulho + 8'd1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            default: w_state_nxt = LIVRE;
        endcase
    end

    // Map storage; a port write is applied after the collection clear so it wins.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wall   <= '0;
            r_debris <= '0;
        end else begin
            if (w_clear_en) begin
                r_debris[r_alvo] <= 1'b0;
            end
            if (map_we) begin
                r_wall[map_addr]   <= map_wall;
                r_debris[map_addr] <= map_debris;
            end
        end
    end

    // Sensors sampled from the pose and map as they stand before this edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_head    <= 1'b0;
            r_left    <= 1'b0;
            r_under   <= 1'b0;
            r_barrier <= 1'b0;
        end else begin
            r_head    <= w_front_wall;
            r_left    <= w_left_wall;
            r_under   <= (r_pos_x == COORD_W'(EXIT_X)) && (r_pos_y == COORD_W'(EXIT_Y));
            r_barrier <= w_barrier;
        end
    end

`ifdef ROBO_AMBIENTE_VISITADOS_EN
    localparam int unsigned VW = AW + 1;
    localparam logic [AW-1:0] START_IDX = {COORD_W'(START_Y), COORD_W'(START_X)};

    logic [CELLS-1:0] r_visited;
    logic [VW-1:0]    r_vis_cnt;

    // Visited bitmap: marks each new destination and counts distinct cells.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_visited <= CELLS'(1) << START_IDX;
            r_vis_cnt <= VW'(1);
        end else if (w_move_en && !r_visited[w_front_addr]) begin
            r_visited[w_front_addr] <= 1'b1;
            r_vis_cnt               <= r_vis_cnt + VW'(1);
        end
    end

    assign visitados_cnt = r_vis_cnt;
`endif

    assign head        = r_head;
    assign left        = r_left;
    assign under       = r_under;
    assign barrier     = r_barrier;
    assign pos_x       = r_pos_x;
    assign pos_y       = r_pos_y;
    assign dir         = r_dir;
    assign busy        = r_busy;
    assign colisao     = r_colisao;
    assign cmd_erro    = r_cmd_erro;
    assign entulho_cnt = r_entulho;

endmodule
